// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM states, digit width and the minimum-digit-count helper for bin2bcd_seq
package bin2bcd_pkg;
  localparam int DW = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int min_nd(input int w, input bit sg);
    longint mx, p;
    int nd;
    mx = sg ? (64'sd1 <<< (w - 1)) : ((64'sd1 <<< w) - 64'sd1);
    p = 64'sd1;
    nd = 0;
    while (p <= mx) begin
      p = p * 64'sd10;
      nd++;
    end
    return nd;
  endfunction
endpackage

// File: rtl/bcd_dabble_adj.sv
// bcd_dabble_adj: adds 3 to every BCD digit >= 5 (d: ND packed digits in, q: adjusted digits out)
module bcd_dabble_adj import bin2bcd_pkg::*; #(
  parameter int ND = 3
) (
  input  logic [DW*ND-1:0] d,
  output logic [DW*ND-1:0] q
);
  for (genvar i = 0; i < ND; i++) begin : g_dig
    assign q[DW*i+:DW] = d[DW*i+:DW] >= DW'(5) ? d[DW*i+:DW] + DW'(3) : d[DW*i+:DW];
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
// ports: clk/rst_b (async active-low), start+bin in; busy, done pulse, bcd, msd, ndig out;
// neg out and two's-complement input only when BIN2BCD_SIGNED_EN is defined
module bin2bcd_seq import bin2bcd_pkg::*; #(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     start,
  input  logic [W-1:0]             bin,
  output logic                     busy,
  output logic                     done,
  output logic [DW*ND-1:0]         bcd,
  output logic [3:0]               msd,
  output logic [$clog2(ND+1)-1:0]  ndig
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                     neg
`endif
);
  localparam int NW = $clog2(ND + 1);
  localparam int CW = $clog2(W + 1);
`ifdef BIN2BCD_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif
  if (ND < min_nd(W, SG)) begin : g_nd_chk
    $error("bin2bcd_seq: ND too small for W");
  end
  state_t st;
  logic [W-1:0] sr, mag;
  logic [DW*ND-1:0] acc, adj, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] m;
  logic [NW-1:0] n;
`ifdef BIN2BCD_SIGNED_EN
  logic negc;
  // -(-2^(W-1)) wraps to 2^(W-1), which is exactly the required magnitude as unsigned
  assign mag = bin[W-1] ? -bin : bin;
`else
  assign mag = bin;
`endif
  bcd_dabble_adj #(.ND(ND)) u_adj (.d(acc), .q(adj));
  // top adjusted bit is always 0 because ND covers the full range
  assign nxt = (DW*ND)'({adj, sr[W-1]});
  always_comb begin
    m = '0;
    n = NW'(1);
    for (int i = 0; i < ND; i++)
      if (nxt[DW*i+:DW] != '0) begin
        m = nxt[DW*i+:DW];
        n = NW'(i + 1);
      end
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      st   <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
      msd  <= '0;
      ndig <= '0;
      sr   <= '0;
      acc  <= '0;
      cnt  <= '0;
`ifdef BIN2BCD_SIGNED_EN
      neg  <= 1'b0;
      negc <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (st == SHIFT) begin
        acc <= nxt;
        sr  <= sr << 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          st   <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= nxt;
          msd  <= m;
          ndig <= n;
`ifdef BIN2BCD_SIGNED_EN
          neg  <= negc;
`endif
        end
      end else if (start) begin
        st   <= SHIFT;
        busy <= 1'b1;
        sr   <= mag;
        acc  <= '0;
        cnt  <= CW'(W);
`ifdef BIN2BCD_SIGNED_EN
        negc <= bin[W-1];
`endif
      end else
        st <= IDLE;
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized scoreboard bench for bin2bcd_seq against an arithmetic decimal model
module tb_bin2bcd_seq;
  localparam int W  = 8;
  localparam int ND = 3;
  localparam int NW = $clog2(ND + 1);
  typedef struct {
    int              c0;
    logic [4*ND-1:0] bcd;
    logic [3:0]      msd;
    logic [NW-1:0]   ndig;
    logic            neg;
  } exp_t;
  logic clk = 1'b0, rst_b = 1'b0, start = 1'b0;
  logic [W-1:0] bin = '0;
  logic busy, done, neg_o;
  logic [4*ND-1:0] bcd;
  logic [3:0] msd;
  logic [NW-1:0] ndig;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  logic [4*ND-1:0] last_bcd = '0;
  logic [3:0] last_msd = '0;
  logic [NW-1:0] last_ndig = '0;
  logic last_neg = 1'b0;
  bin2bcd_seq #(.W(W), .ND(ND)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .msd(msd), .ndig(ndig)
`ifdef BIN2BCD_SIGNED_EN
    , .neg(neg_o)
`endif
  );
`ifndef BIN2BCD_SIGNED_EN
  assign neg_o = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] v, input int c0);
    exp_t e;
    int unsigned mg, t;
    e.c0 = c0;
    e.neg = 1'b0;
    mg = v;
`ifdef BIN2BCD_SIGNED_EN
    if (v[W-1]) begin
      e.neg = 1'b1;
      mg = (1 << W) - v;
    end
`endif
    e.bcd = '0;
    t = mg;
    for (int k = 0; k < ND; k++) begin
      e.bcd[4*k+:4] = 4'(t % 10);
      t = t / 10;
    end
    e.ndig = NW'(1);
    t = mg;
    while (t >= 10) begin
      t = t / 10;
      e.ndig++;
    end
    e.msd = 4'(t);
    return e;
  endfunction
  always begin
    logic ed, eb;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    ed = q.size() > 0 && cyc == q[0].c0 + W;
    eb = q.size() > 0 && cyc >= q[0].c0 && cyc < q[0].c0 + W;
    chk("done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), 32'(eb));
    if (ed) begin
      e = q.pop_front();
      last_bcd = e.bcd;
      last_msd = e.msd;
      last_ndig = e.ndig;
      last_neg = e.neg;
    end
    chk("bcd", 32'(bcd), 32'(last_bcd));
    chk("msd", 32'(msd), 32'(last_msd));
    chk("ndig", 32'(ndig), 32'(last_ndig));
    chk("neg", 32'(neg_o), 32'(last_neg));
  end
  task automatic issue(input logic [W-1:0] v, input bit hold);
    @(negedge clk);
    start = 1'b1;
    bin = v;
    q.push_back(model(v, cyc + 1));
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      bin = W'($urandom);
    end
  endtask
  task automatic idle_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      bin = W'($urandom);
    end
  endtask
  task automatic conv(input logic [W-1:0] v);
    issue(v, 1'b0);
    idle_wait(W + 1);
  endtask
  task automatic check_zero(input string tag);
    #1;
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_bcd"}, 32'(bcd), 0);
    chk({tag, "_msd"}, 32'(msd), 0);
    chk({tag, "_ndig"}, 32'(ndig), 0);
    chk({tag, "_neg"}, 32'(neg_o), 0);
  endtask
  initial begin
    check_zero("rst0");
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    conv(8'd255);
    conv(8'd0);
    conv(8'd9);
    conv(8'd10);
    issue(8'd123, 1'b0);
    @(negedge clk);
    start = 1'b1;
    bin = 8'd45;
    @(negedge clk);
    start = 1'b0;
    idle_wait(W);
    issue(8'd200, 1'b1);
    idle_wait(W);
    issue(8'd7, 1'b0);
    idle_wait(W + 1);
    issue(8'd99, 1'b0);
    idle_wait(3);
    @(negedge clk);
    rst_b = 1'b0;
    q.delete();
    last_bcd = '0;
    last_msd = '0;
    last_ndig = '0;
    last_neg = 1'b0;
    check_zero("rstmid");
    @(negedge clk);
    rst_b = 1'b1;
    idle_wait(2);
    conv(8'd77);
    conv(8'h80);
    conv(8'hFF);
    for (int i = 0; i < 30; i++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      issue(W'($urandom), h);
      if (h) idle_wait(W);
      else idle_wait(W - 1 + $urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1'b0;
    idle_wait(W + 4);
    chk("drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
